// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 10-bit register/ALU datapath.
// Fetches into its own IR and steps T0..T3 with registered control strobes.
module instr_sequencer #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] ir,
    output logic [1:0]        t_step,
    output logic              busy,
    output logic [2:0]        alu_op,
    output logic [2:0]        rin,
    output logic [2:0]        rout,
    output logic              enw,
    output logic              enr,
    output logic              ain,
    output logic              gin,
    output logic              gout,
    output logic              ext,
    output logic              irin,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3
    } state_e;

    typedef struct packed {
        logic [1:0] t_step;
        logic       busy;
        logic [2:0] alu_op;
        logic [2:0] rin;
        logic [2:0] rout;
        logic       enw;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       ext;
        logic       irin;
        logic       done;
    } ctrl_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_INV  = 3'b100;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    ctrl_t              ctrl_q;
    logic [CNT_W-1:0]   retired_q;

    // Strobes for a given state and instruction; all-zero unless listed.
    function automatic ctrl_t decode(state_e st, logic [2:0] x,
                                     logic [2:0] y, logic [2:0] op);
        ctrl_t c;
        c = '0;
        unique case (st)
            S_IDLE: ;
            S_T0: begin
                c.busy = 1'b1;
                c.ext  = 1'b1;
                c.irin = 1'b1;
            end
            S_T1: begin
                c.busy   = 1'b1;
                c.t_step = 2'd1;
                if (op == OP_LOAD) begin
                    c.ext  = 1'b1;
                    c.enw  = 1'b1;
                    c.rin  = x;
                    c.done = 1'b1;
                end else if (op == OP_MOVE) begin
                    c.enr  = 1'b1;
                    c.rout = y;
                    c.enw  = 1'b1;
                    c.rin  = x;
                    c.done = 1'b1;
                end else begin
                    c.enr  = 1'b1;
                    c.rout = x;
                    c.ain  = 1'b1;
                end
            end
            S_T2: begin
                c.busy   = 1'b1;
                c.t_step = 2'd2;
                c.gin    = 1'b1;
                c.alu_op = op - 3'd2;
                if (op != OP_INV) begin
                    c.enr  = 1'b1;
                    c.rout = y;
                end
            end
            S_T3: begin
                c.busy   = 1'b1;
                c.t_step = 2'd3;
                c.gout   = 1'b1;
                c.enw    = 1'b1;
                c.rin    = x;
                c.done   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: state_d = run ? S_T0 : S_IDLE;
            S_T0: begin
                ir_d    = din;
                state_d = S_T1;
            end
            S_T1: begin
                if (ir_q[2:0] == OP_LOAD || ir_q[2:0] == OP_MOVE)
                    state_d = run ? S_T0 : S_IDLE;
                else
                    state_d = S_T2;
            end
            S_T2: state_d = S_T3;
            S_T3: state_d = run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ctrl_q    <= decode(state_d, ir_d[8:6], ir_d[5:3], ir_d[2:0]);
            retired_q <= retired_q + CNT_W'(ctrl_q.done);
        end
    end

    assign ir      = ir_q;
    assign t_step  = ctrl_q.t_step;
    assign busy    = ctrl_q.busy;
    assign alu_op  = ctrl_q.alu_op;
    assign rin     = ctrl_q.rin;
    assign rout    = ctrl_q.rout;
    assign enw     = ctrl_q.enw;
    assign enr     = ctrl_q.enr;
    assign ain     = ctrl_q.ain;
    assign gin     = ctrl_q.gin;
    assign gout    = ctrl_q.gout;
    assign ext     = ctrl_q.ext;
    assign irin    = ctrl_q.irin;
    assign done    = ctrl_q.done;
    assign retired = retired_q;

endmodule
